// File: rtl/gene_pkg.sv
// rtl/gene_pkg.sv - shared 2-bit nucleotide codes, ASCII constants and mapping helpers
package gene_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_T = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_G = 8'h47;
    localparam logic [7:0] ASCII_T = 8'h54;

    typedef struct packed {
        logic       is_base;
        logic [1:0] code;
    } base_dec_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

    // Setting bit 5 folds upper case onto lower case for letters only.
    function automatic base_dec_t ascii_to_base(input logic [7:0] ch);
        base_dec_t  dec;
        logic [7:0] low;
        low = ch | 8'h20;
        dec = '{is_base: 1'b1, code: BASE_A};
        if (low == (ASCII_A | 8'h20))      dec.code = BASE_A;
        else if (low == (ASCII_C | 8'h20)) dec.code = BASE_C;
        else if (low == (ASCII_T | 8'h20)) dec.code = BASE_T;
        else if (low == (ASCII_G | 8'h20)) dec.code = BASE_G;
        else                               dec = '{is_base: 1'b0, code: 2'b00};
        return dec;
    endfunction

    function automatic logic [7:0] base_to_ascii(input logic [1:0] code);
        logic [7:0] ch;
        case (code)
            BASE_A:  ch = ASCII_A;
            BASE_C:  ch = ASCII_C;
            BASE_T:  ch = ASCII_T;
            default: ch = ASCII_G;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/ascii_base_encoder.sv
// rtl/ascii_base_encoder.sv - combinational ASCII byte to 2-bit base code decoder
module ascii_base_encoder
    import gene_pkg::*;
(
    input  logic [7:0] in_data,
    output logic [1:0] code,
    output logic       is_base
);

    base_dec_t dec;

    always_comb begin
        dec     = ascii_to_base(in_data);
        code    = dec.code;
        is_base = dec.is_base;
    end

endmodule

// File: rtl/ascii_to_twobit_packer.sv
// rtl/ascii_to_twobit_packer.sv - packs an ASCII nucleotide stream into words of 2-bit codes
module ascii_to_twobit_packer
    import gene_pkg::*;
#(
    parameter int BASES_PER_WORD = 4,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [2*BASES_PER_WORD-1:0]       out_data,
    output logic [$clog2(BASES_PER_WORD+1)-1:0] out_count,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              err_pulse,
    output logic [ERR_CNT_W-1:0]              err_count
);

    localparam int DW = 2 * BASES_PER_WORD;
    localparam int CW = $clog2(BASES_PER_WORD + 1);
    localparam int FW = $clog2(BASES_PER_WORD);
    localparam logic [FW-1:0] LAST_SLOT = FW'(BASES_PER_WORD - 1);

    pack_state_t   state;
    logic [FW-1:0] fill_cnt;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [CW-1:0] held_count;
    logic [1:0]    code;
    logic          is_base;
    logic          accept;
    logic          flush;

    ascii_base_encoder u_encoder (
        .in_data (in_data),
        .code    (code),
        .is_base (is_base)
    );

    always_comb begin
        in_ready   = rst_n && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        acc_next   = acc;
        if (is_base) acc_next = acc | (DW'(code) << {fill_cnt, 1'b0});
        held_count = CW'(fill_cnt) + CW'(is_base);
        flush      = accept && ((is_base && (fill_cnt == LAST_SLOT)) || in_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !is_base;
            if (accept && !is_base && (err_count != '1)) err_count <= err_count + 1'b1;

            if (flush) begin
                acc      <= '0;
                fill_cnt <= '0;
            end else if (accept && is_base) begin
                acc      <= acc_next;
                fill_cnt <= fill_cnt + 1'b1;
            end

            // A flush in HOLD implies out_ready, so the held word is consumed as the new one loads.
            case (state)
                ST_FILL: begin
                    if (flush) begin
                        out_data  <= acc_next;
                        out_count <= held_count;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        out_data  <= acc_next;
                        out_count <= held_count;
                        out_last  <= in_last;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_to_twobit_packer.sv
// tb/tb_ascii_to_twobit_packer.sv - randomized self-checking bench with a queue-based reference model
module tb_ascii_to_twobit_packer;

    localparam int BPW  = 4;
    localparam int ECW  = 4;
    localparam int ESAT = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [2*BPW-1:0] out_data;
    logic [2:0]     out_count;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic           err_pulse;
    logic [ECW-1:0] err_count;

    ascii_to_twobit_packer #(.BASES_PER_WORD(BPW), .ERR_CNT_W(ECW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int count;
        int last;
    } word_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t words[$];
    int    bases[$];
    int    exp_cnt   = 0;
    int    exp_pulse = 0;

    task automatic check(input string tag, input int observed, input int expected);
        n_tests++;
        if (observed != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    function automatic int decode(input logic [7:0] b);
        case (b)
            8'h41, 8'h61: return 0;
            8'h43, 8'h63: return 1;
            8'h54, 8'h74: return 2;
            8'h47, 8'h67: return 3;
            default:      return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic last);
        int    c;
        word_t w;
        c = decode(b);
        if (c < 0) begin
            exp_pulse = 1;
            if (exp_cnt < ESAT) exp_cnt++;
        end else begin
            bases.push_back(c);
        end
        if (bases.size() == BPW || last) begin
            w.data = 0;
            for (int k = 0; k < bases.size(); k++) w.data += bases[k] * (4 ** k);
            w.count = bases.size();
            w.last  = last ? 1 : 0;
            words.push_back(w);
            bases.delete();
        end
    endtask

    // Called on a falling edge; returns on the next falling edge after checking outputs.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic il, input logic ordy);
        int    exp_ready;
        logic  acc;
        out_ready = ordy;
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        #1;
        exp_ready = (words.size() == 0 || ordy) ? 1 : 0;
        check("in_ready", int'(in_ready), exp_ready);
        acc = iv && (exp_ready != 0);
        @(posedge clk);
        if (words.size() != 0 && ordy) void'(words.pop_front());
        exp_pulse = 0;
        if (acc) model_byte(d, il);
        @(negedge clk);
        check("out_valid", int'(out_valid), (words.size() != 0) ? 1 : 0);
        if (words.size() != 0) begin
            check("out_data", int'(out_data), words[0].data);
            check("out_count", int'(out_count), words[0].count);
            check("out_last", int'(out_last), words[0].last);
        end
        check("err_pulse", int'(err_pulse), exp_pulse);
        check("err_count", int'(err_count), exp_cnt);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_err_pulse", int'(err_pulse), 0);
        check("rst_err_count", int'(err_count), 0);
        words.delete();
        bases.delete();
        exp_cnt   = 0;
        exp_pulse = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            cycle(1'b1, s[i], last_on_end && (i == s.len() - 1), 1'b1);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] tbl[8];
        tbl = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74};
        if ($urandom_range(9) < 7) return tbl[$urandom_range(7)];
        return 8'($urandom);
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        send_str("CGTA", 1'b0);
        check("cgta_data", int'(out_data), 8'h2D);
        check("cgta_count", int'(out_count), 4);
        check("cgta_last", int'(out_last), 0);

        send_str("acg", 1'b1);
        check("acg_data", int'(out_data), 8'h34);
        check("acg_count", int'(out_count), 3);
        check("acg_last", int'(out_last), 1);

        send_str("ANC\nGT", 1'b0);
        check("mixed_data", int'(out_data), 8'hB4);
        check("mixed_err_count", int'(err_count), 2);

        cycle(1'b1, 8'h41, 1'b0, 1'b1);
        send_str("CGT", 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h47, 1'b0, 1'b0);
        check("bp_stable", int'(out_data), 8'hB4 & 8'h00 | 8'hB4);
        send_str("TTTT", 1'b0);
        send_str("GGGG", 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        do_reset();
        send_str("X", 1'b1);
        check("lone_count", int'(out_count), 0);
        check("lone_data", int'(out_data), 0);
        check("lone_last", int'(out_last), 1);
        check("lone_err_count", int'(err_count), 1);

        cycle(1'b1, 8'h41, 1'b0, 1'b1);
        cycle(1'b1, 8'h43, 1'b0, 1'b1);
        @(negedge clk);
        do_reset();
        send_str("GTCA", 1'b0);
        check("post_rst_data", int'(out_data), 8'h1B);
        check("post_rst_count", int'(out_count), 4);

        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h2A, 1'b0, 1'b1);
        check("sat_count", int'(err_count), ESAT);
        cycle(1'b1, 8'h2A, 1'b1, 1'b1);
        check("sat_pulse", int'(err_pulse), 1);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(3) != 0, rand_byte(), $urandom_range(7) == 0,
                      $urandom_range(3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_to_twobit_packer.md
# ascii_to_twobit_packer

Streaming encoder that turns an ASCII nucleotide byte stream into packed 2-bit base codes. It is the inverse of the 2-bit-to-ASCII expansion stage. It sits at the compressor input: raw genome text enters over a valid/ready byte interface, and packed words of BASES_PER_WORD bases leave over a valid/ready word interface. Non-nucleotide bytes are dropped and counted.

## Interface
- BASES_PER_WORD, default 4: bases packed per output word; legal values 2..16.
- ERR_CNT_W, default 16: width of the invalid-byte counter.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  byte is the final byte of the sequence.
- in_ready  out  1  block accepts the byte this cycle.
- out_data  out  2*BASES_PER_WORD  packed codes; base k occupies bits [2k+1:2k], first base received in [1:0].
- out_count  out  $clog2(BASES_PER_WORD+1)  number of valid bases in out_data, 0..BASES_PER_WORD.
- out_last  out  1  word closes the sequence.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- err_pulse  out  1  one-cycle pulse: accepted byte was not a nucleotide.
- err_count  out  ERR_CNT_W  saturating count of invalid bytes since reset.

## Operation
- Code map, upper or lower case: A/a (0x41/0x61) -> 00, C/c (0x43/0x63) -> 01, T/t (0x54/0x74) -> 10, G/g (0x47/0x67) -> 11. Every other byte is invalid.
- A byte is accepted when in_valid && in_ready.
- Accepted valid base:
  - Written into the accumulator at slot fill_cnt; fill_cnt increments.
  - When the slot was BASES_PER_WORD-1, the accumulator plus this base load the output register with out_count = BASES_PER_WORD.
  - fill_cnt then returns to 0 and the accumulator clears to 0.
- Accepted invalid byte:
  - Not stored.
  - err_pulse asserts next cycle.
  - err_count increments and saturates at all-ones.
- Accepted byte with in_last:
  - The output register loads the current accumulator, including this byte's code if it is valid.
  - out_count is the number of bases held; out_last = 1.
  - fill_cnt resets to 0.
  - If zero bases are held, the block still emits a word: out_count = 0, out_data = 0, out_last = 1.
- Unused slots of a partial word are 0.
- States:
  - FILL: output register empty.
  - HOLD: out_valid = 1, word not yet taken.
  - FILL -> HOLD on a completed or last word.
  - HOLD -> FILL on out_ready when no new word completes the same cycle.
  - HOLD -> HOLD on out_ready when a new word completes the same cycle (back-to-back).

## Timing
- in_ready = rst_n && (!out_valid || out_ready). Combinational, no other input dependence.
- Latency: out_valid rises on the clock edge that accepts the completing or last byte, and is visible the next cycle.
- With out_ready held high, throughput is one byte per cycle.
- out_data, out_count and out_last are stable while out_valid && !out_ready.
- Reset values:
  - out_valid 0, out_data 0, out_count 0, out_last 0.
  - err_pulse 0, err_count 0.
  - fill_cnt 0, accumulator 0; state FILL.
  - in_ready 0 while rst_n is low, 1 on the first cycle after release.
- Reset mid-word or in HOLD discards the partial or held data with no output.
- Simultaneous invalid byte and in_last: err_pulse asserts and the partial word flushes.
- err_count at saturation stays saturated; err_pulse still fires.

## Structure
- Shared package gene_pkg holds:
  - Code localparams BASE_A=2'b00, BASE_C=2'b01, BASE_T=2'b10, BASE_G=2'b11.
  - ASCII constants for A/C/G/T.
  - A shared function for the code <-> ASCII mapping, also usable by the expansion stage.
- Sub-module ascii_base_encoder: combinational, in_data[7:0] -> code[1:0] plus is_base.
- Top level holds the accumulator, fill counter, output register, FSM and error counter.

## Test plan
- Reset, then bytes "C","G","T","A" (0x43,0x47,0x54,0x41), out_ready=1 -> one word, out_data=8'b00_10_11_01, out_count=4, out_last=0, one cycle after "A".
- "acg" with in_last on "g" -> out_data=8'b00_11_01_00 (0x34), out_count=3, out_last=1.
- "A","N","C","\n","G","T" -> word 8'b10_11_01_00 (0xB4); err_pulse twice; err_count=2.
- out_ready=0 after the first word while 8 bytes are offered -> in_ready=0; the word is stable until out_ready=1; then the second word follows with no loss.
- Lone 0x58 ("X") with in_last -> out_count=0, out_data=0, out_last=1, err_count=1.
- rst_n pulsed low after 2 bases accepted -> no output word; the next 4 bases form a clean word.
